// File: rtl/fp_accum_pkg.sv
// fp_accum_pkg: shared widths, FSM states and IEEE-754 single field helpers.
package fp_accum_pkg;
   localparam int DATA_WIDTH = 32;
   localparam int CNT_WIDTH = 16;
   localparam logic [7:0] EXP_MAX = 8'hFF;
   typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, OUT} state_t;
   function automatic logic [23:0] mant(input logic [31:0] x);
      return x[30:23] == 8'd0 ? 24'd0 : {1'b1, x[22:0]};
   endfunction
   function automatic logic [30:0] mag(input logic [31:0] x);
      return x[30:23] == 8'd0 ? 31'd0 : x[30:0];
   endfunction
endpackage

// File: rtl/fp_accum_if.sv
// fp_accum_if: product input stream and sum output stream of the accumulator.
interface fp_accum_if #(
   parameter int DATA_WIDTH = fp_accum_pkg::DATA_WIDTH,
   parameter int CNT_WIDTH = fp_accum_pkg::CNT_WIDTH
);
   logic prod_valid;
   logic prod_ready;
   logic [DATA_WIDTH-1:0] prod_data;
   logic prod_last;
   logic acc_valid;
   logic acc_ready;
   logic [DATA_WIDTH-1:0] acc_data;
   logic [CNT_WIDTH-1:0] acc_count;
   modport master (output prod_valid, prod_data, prod_last, acc_ready,
                   input prod_ready, acc_valid, acc_data, acc_count);
   modport slave (input prod_valid, prod_data, prod_last, acc_ready,
                  output prod_ready, acc_valid, acc_data, acc_count);
endinterface

// File: rtl/fp_accum_detect_pos_first_one.sv
// detect_pos_first_one: index of the most significant set bit, with a found flag.
module detect_pos_first_one #(
   parameter int D_WIDTH = 25
) (
   input logic [D_WIDTH-1:0] data,
   output logic [$clog2(D_WIDTH)-1:0] pos,
   output logic found
);
   always_comb begin
      pos = '0;
      found = 1'b0;
      for (int i = 0; i < D_WIDTH; i++)
         if (data[i]) begin
            pos = i[$clog2(D_WIDTH)-1:0];
            found = 1'b1;
         end
   end
endmodule

// File: rtl/fp_accum.sv
// fp_accum: streaming IEEE-754 single accumulator; align/add/normalize over
// three cycles per element, emits the truncated sum and count on the last element.
module fp_accum
   import fp_accum_pkg::*;
(
   input logic clk,
   input logic rst,
   fp_accum_if.slave bus
);
   state_t state, nxt;
   logic [31:0] sum, op, a, b, norm;
   logic [CNT_WIDTH-1:0] count;
   logic last_q, inf_q, isg_q, sa_q, sb_q, swap, xfer, done, found;
   logic [7:0] ea_q, diff;
   logic [23:0] ma_q, mb_q, mb_al;
   logic [24:0] res_q;
   logic [22:0] shl, f_n;
   logic [4:0] pos, sh;
   logic signed [9:0] e_n;
   assign xfer = bus.prod_valid && bus.prod_ready;
   assign done = bus.acc_valid && bus.acc_ready;
   // A is always the larger magnitude so the subtraction never goes negative
   assign swap = mag(op) > mag(sum);
   assign a = swap ? op : sum;
   assign b = swap ? sum : op;
   assign diff = a[30:23] - b[30:23];
   assign mb_al = diff > 8'd25 ? 24'd0 : mant(b) >> diff;
   detect_pos_first_one #(.D_WIDTH(25)) u_lod (.data(res_q), .pos(pos), .found(found));
   assign sh = 5'd23 - pos;
   assign shl = 23'(res_q << sh);
   assign f_n = res_q[24] ? res_q[23:1] : shl;
   assign e_n = res_q[24] ? $signed({2'b00, ea_q}) + 10'sd1
                          : $signed({2'b00, ea_q}) - $signed({5'd0, sh});
   assign norm = inf_q ? {isg_q, EXP_MAX, 23'd0}
               : (!found || e_n < 10'sd1) ? 32'd0
               : e_n > 10'sd254 ? {sa_q, EXP_MAX, 23'd0}
               : {sa_q, e_n[7:0], f_n};
   always_comb begin
      nxt = state;
      bus.prod_ready = 1'b0;
      bus.acc_valid = 1'b0;
      case (state)
         IDLE: begin
            bus.prod_ready = 1'b1;
            if (bus.prod_valid) nxt = ALIGN;
         end
         ALIGN: nxt = ADD;
         ADD: nxt = NORM;
         NORM: if (last_q) nxt = OUT; else nxt = IDLE;
         OUT: begin
            bus.acc_valid = 1'b1;
            if (bus.acc_ready) nxt = IDLE;
         end
         default: nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         sum <= '0;
         op <= '0;
         count <= '0;
         last_q <= 1'b0;
         inf_q <= 1'b0;
         isg_q <= 1'b0;
         sa_q <= 1'b0;
         sb_q <= 1'b0;
         ea_q <= '0;
         ma_q <= '0;
         mb_q <= '0;
         res_q <= '0;
         bus.acc_data <= '0;
         bus.acc_count <= '0;
      end else begin
         state <= nxt;
         if (xfer) begin
            op <= bus.prod_data;
            last_q <= bus.prod_last;
            count <= count + 1'b1;
         end
         if (state == ALIGN) begin
            inf_q <= sum[30:23] == EXP_MAX || op[30:23] == EXP_MAX;
            isg_q <= sum[30:23] == EXP_MAX ? sum[31] : op[31];
            sa_q <= a[31];
            sb_q <= b[31];
            ea_q <= a[30:23];
            ma_q <= mant(a);
            mb_q <= mb_al;
         end
         if (state == ADD)
            res_q <= sa_q == sb_q ? {1'b0, ma_q} + {1'b0, mb_q} : {1'b0, ma_q} - {1'b0, mb_q};
         if (state == NORM) begin
            sum <= norm;
            if (last_q) begin
               bus.acc_data <= norm;
               bus.acc_count <= count;
            end
         end
         if (done) begin
            sum <= '0;
            count <= '0;
         end
      end
endmodule

// File: tb/tb_fp_accum.sv
// tb_fp_accum: directed and randomized checks of fp_accum against a behavioural model.
module tb_fp_accum;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int checks = 0;
   int passes = 0;
   int lat;
   logic [31:0] d, prev, exp_sum;
   int len;
   fp_accum_if bus ();
   fp_accum dut (.clk(clk), .rst(rst), .bus(bus.slave));
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   // Truncating float add from the arithmetic rules, using plain integers
   function automatic logic [31:0] ref_add(input logic [31:0] s, input logic [31:0] o);
      logic [31:0] x, y;
      longint mx, my, r;
      int ex, ey;
      if (s[30:23] == 8'hFF) return {s[31], 8'hFF, 23'd0};
      if (o[30:23] == 8'hFF) return {o[31], 8'hFF, 23'd0};
      x = s;
      y = o;
      ex = int'(s[30:23]);
      ey = int'(o[30:23]);
      mx = ex == 0 ? 0 : 64'h800000 + longint'(s[22:0]);
      my = ey == 0 ? 0 : 64'h800000 + longint'(o[22:0]);
      if (ey > ex || (ey == ex && my > mx)) begin
         x = o; y = s;
         {ex, ey} = {ey, ex};
         {mx, my} = {my, mx};
      end
      my = (ex - ey > 25) ? 0 : my >> (ex - ey);
      r = x[31] == y[31] ? mx + my : mx - my;
      if (r == 0) return 32'd0;
      while (r >= 64'h1000000) begin r = r >> 1; ex++; end
      while (r < 64'h800000) begin r = r << 1; ex--; end
      if (ex > 254) return {x[31], 8'hFF, 23'd0};
      if (ex < 1) return 32'd0;
      return {x[31], ex[7:0], r[22:0]};
   endfunction

   function automatic logic [31:0] rnd_fp(input logic [31:0] p);
      int sel;
      sel = $urandom_range(0, 11);
      if (sel == 0) return $urandom;
      if (sel == 1) return {~p[31], p[30:0]};
      if (sel == 2) return {1'($urandom), 8'd0, 23'($urandom)};
      if (sel == 3) return {1'($urandom), 8'($urandom_range(240, 254)), 23'($urandom)};
      return {1'($urandom), 8'($urandom_range(115, 140)), 23'($urandom)};
   endfunction

   task automatic send(input logic [31:0] v, input logic l);
      int n = 0;
      @(negedge clk);
      bus.prod_valid = 1'b1;
      bus.prod_data = v;
      bus.prod_last = l;
      while (!bus.prod_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      check("send_ready", {31'd0, bus.prod_ready}, 32'd1);
      @(posedge clk);
      #1 bus.prod_valid = 1'b0;
      bus.prod_last = 1'b0;
   endtask

   task automatic recv(input logic [31:0] ed, input logic [15:0] ec, input int hold, output int l);
      l = 0;
      do begin
         @(negedge clk);
         l++;
      end while (!bus.acc_valid && l < 100);
      check("acc_valid", {31'd0, bus.acc_valid}, 32'd1);
      check("acc_data", bus.acc_data, ed);
      check("acc_count", {16'd0, bus.acc_count}, {16'd0, ec});
      for (int i = 0; i < hold; i++) begin
         bus.prod_valid = 1'b1;
         bus.prod_data = $urandom;
         @(negedge clk);
         check("hold_valid", {31'd0, bus.acc_valid}, 32'd1);
         check("hold_data", bus.acc_data, ed);
         check("hold_count", {16'd0, bus.acc_count}, {16'd0, ec});
         check("hold_prod_ready", {31'd0, bus.prod_ready}, 32'd0);
      end
      bus.prod_valid = 1'b0;
      bus.acc_ready = 1'b1;
      @(posedge clk);
      #1 bus.acc_ready = 1'b0;
      @(negedge clk);
      check("valid_drop", {31'd0, bus.acc_valid}, 32'd0);
      check("data_held", bus.acc_data, ed);
   endtask

   initial begin
      bus.prod_valid = 1'b0;
      bus.prod_data = '0;
      bus.prod_last = 1'b0;
      bus.acc_ready = 1'b0;
      #1;
      check("rst_valid", {31'd0, bus.acc_valid}, 32'd0);
      check("rst_data", bus.acc_data, 32'd0);
      check("rst_count", {16'd0, bus.acc_count}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("idle_ready", {31'd0, bus.prod_ready}, 32'd1);
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b1);
      recv(32'h40400000, 16'd2, 0, lat);
      check("latency", lat, 32'd4);
      send(32'hC0A00000, 1'b1);
      recv(32'hC0A00000, 16'd1, 0, lat);
      send(32'h3F800000, 1'b1);
      recv(32'h3F800000, 16'd1, 0, lat);
      send(32'h3F800000, 1'b0);
      send(32'hBF800000, 1'b1);
      recv(32'h00000000, 16'd2, 0, lat);
      send(32'h4B800000, 1'b0);
      send(32'h3F800000, 1'b1);
      recv(32'h4B800000, 16'd2, 0, lat);
      send(32'h40000000, 1'b1);
      recv(32'h40000000, 16'd1, 6, lat);
      send(32'h7F7FFFFF, 1'b0);
      send(32'h7F7FFFFF, 1'b1);
      recv(32'h7F800000, 16'd2, 0, lat);
      send(32'h3F800000, 1'b0);
      send(32'h40000000, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      check("arst_valid", {31'd0, bus.acc_valid}, 32'd0);
      check("arst_data", bus.acc_data, 32'd0);
      check("arst_count", {16'd0, bus.acc_count}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      send(32'h40400000, 1'b1);
      recv(32'h40400000, 16'd1, 0, lat);
      prev = 32'h3F800000;
      for (int v = 0; v < 40; v++) begin
         len = $urandom_range(1, 6);
         exp_sum = 32'd0;
         for (int k = 0; k < len; k++) begin
            d = rnd_fp(prev);
            prev = d;
            exp_sum = ref_add(exp_sum, d);
            send(d, k == len - 1);
         end
         recv(exp_sum, 16'(len), $urandom_range(0, 3), lat);
         check("rnd_latency", lat, 32'd4);
      end
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
